// File: rtl/descrypt16_ctrl_pkg.sv
// Shared widths, phase encoding and timing helpers for the descrypt16 batch sequencer.
package descrypt16_ctrl_pkg;

  localparam int unsigned SaltMsb            = 11;
  localparam int unsigned HashMsb            = 63;
  localparam int unsigned DescryptIterations = 25;
  localparam int unsigned DescryptSlots      = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCrypt,
    StUnload
  } ctrl_state_e;

  // Index of the final CRYPT cycle: the core circulates (iterations - 1) full turns unattended.
  function automatic logic [8:0] crypt_last(input int unsigned iterations,
                                            input int unsigned slots);
    return 9'((iterations - 1) * slots - 1);
  endfunction

endpackage

// File: rtl/descrypt_unload_cmp.sv
// Accumulates the per-slot match mask while the departing batch drains out of the core.
module descrypt_unload_cmp
  import descrypt16_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [HashMsb:0] target_i,
  input  logic [HashMsb:0] core_hash_i,
  input  logic             core_valid_i,
  input  logic [3:0]       slot_i,
  input  logic             active_i,
  output logic [15:0]      mask_o
);

  logic [15:0] acc_q;
  logic [15:0] base;
  logic [15:0] hit;

  // mask_o already includes the current slot so the final slot can be committed on its own edge.
  always_comb begin
    base = (slot_i == 4'd0) ? 16'h0000 : acc_q;
    hit  = 16'h0000;
    if (active_i && core_valid_i && (core_hash_i == target_i)) begin
      hit[slot_i] = 1'b1;
    end
    mask_o = base | hit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= 16'h0000;
    end else if (active_i) begin
      acc_q <= mask_o;
    end
  end

endmodule

// File: rtl/descrypt16_ctrl.sv
// Batch sequencer for the 16-slot descrypt core: loads keys, holds the core for all passes,
// and collects a per-batch match mask into a host-readable result register.
module descrypt16_ctrl
  import descrypt16_ctrl_pkg::*;
#(
  parameter int unsigned ITERATIONS = DescryptIterations,
  parameter int unsigned NUM_SLOTS  = DescryptSlots
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [SaltMsb:0] salt_in,
  input  logic [HashMsb:0] cmp_hash_in,
  input  logic [55:0]      key56_in,
  input  logic             key_valid,
  output logic             key_rd,
  output logic [SaltMsb:0] core_salt,
  output logic [55:0]      core_key56,
  output logic             core_valid,
  output logic             ENABLE_CRYPT,
  output logic             START_CRYPT,
  input  logic [HashMsb:0] core_hash,
  input  logic             core_valid_out,
  output logic             result_valid,
  output logic [15:0]      result_mask,
  output logic [15:0]      result_batch,
  input  logic             result_rd,
  output logic             overrun,
  output logic             idle
);

  localparam logic [8:0] CryptLast = crypt_last(ITERATIONS, NUM_SLOTS);
  localparam logic [3:0] SlotLast  = 4'(NUM_SLOTS - 1);

  ctrl_state_e      state_q;
  logic [3:0]       slot_q;
  logic [8:0]       crypt_q;
  logic [SaltMsb:0] batch_salt_q;
  logic [HashMsb:0] batch_cmp_q;
  logic             window_q;
  logic [15:0]      batch_q;
  logic [15:0]      unload_mask;
  logic             commit;
  logic             keep_salt;

  assign key_rd     = (state_q == StLoad);
  assign core_valid = key_rd & key_valid;
  assign core_key56 = key_rd ? key56_in : 56'd0;
  assign core_salt  = batch_salt_q;
  assign commit     = window_q && (slot_q == SlotLast);
  // Overlapping the next load is only safe when no slot would see a salt change mid-hash.
  assign keep_salt  = key_valid && (salt_in == batch_salt_q);

  descrypt_unload_cmp u_unload_cmp (
    .clk_i        (CLK),
    .rst_i        (RESET),
    .target_i     (batch_cmp_q),
    .core_hash_i  (core_hash),
    .core_valid_i (core_valid_out),
    .slot_i       (slot_q),
    .active_i     (window_q),
    .mask_o       (unload_mask)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      slot_q       <= 4'd0;
      crypt_q      <= 9'd0;
      batch_salt_q <= '0;
      batch_cmp_q  <= '0;
      window_q     <= 1'b0;
      batch_q      <= 16'd0;
      ENABLE_CRYPT <= 1'b0;
      START_CRYPT  <= 1'b0;
      idle         <= 1'b1;
      result_valid <= 1'b0;
      result_mask  <= 16'd0;
      result_batch <= 16'd0;
      overrun      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (key_valid) begin
            state_q      <= StLoad;
            slot_q       <= 4'd0;
            window_q     <= 1'b0;
            batch_salt_q <= salt_in;
            batch_cmp_q  <= cmp_hash_in;
            ENABLE_CRYPT <= 1'b1;
            START_CRYPT  <= 1'b1;
            idle         <= 1'b0;
          end
        end
        StLoad: begin
          slot_q <= slot_q + 4'd1;
          if (slot_q == SlotLast) begin
            state_q     <= StCrypt;
            crypt_q     <= 9'd0;
            START_CRYPT <= 1'b0;
            window_q    <= 1'b0;
            // In an overlapped load the departing batch owned batch_cmp until this edge.
            if (window_q) begin
              batch_cmp_q <= cmp_hash_in;
            end
          end
        end
        StCrypt: begin
          crypt_q <= crypt_q + 9'd1;
          if (crypt_q == CryptLast) begin
            state_q     <= keep_salt ? StLoad : StUnload;
            slot_q      <= 4'd0;
            window_q    <= 1'b1;
            START_CRYPT <= 1'b1;
          end
        end
        StUnload: begin
          slot_q <= slot_q + 4'd1;
          if (slot_q == SlotLast) begin
            window_q <= 1'b0;
            if (key_valid) begin
              state_q      <= StLoad;
              batch_salt_q <= salt_in;
              batch_cmp_q  <= cmp_hash_in;
            end else begin
              state_q      <= StIdle;
              START_CRYPT  <= 1'b0;
              ENABLE_CRYPT <= 1'b0;
              idle         <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      if (commit) begin
        result_mask  <= unload_mask;
        result_batch <= batch_q;
        result_valid <= 1'b1;
        batch_q      <= batch_q + 16'd1;
        if (result_valid && !result_rd) begin
          overrun <= 1'b1;
        end
      end else if (result_rd) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule
